chip8_fb_controller: RTL

// - Owns the 64x32 Chip-8 framebuffer and sequences every write to it: clear-screen and sprite
//   XOR-draw requests from the CPU core, with collision reporting.
// - Presents a tear-free display copy on `framebuffer` to the VGA emulator.
// - The display copy is refreshed at vertical blank.
// - Sits between the Chip-8 CPU (draw/clear requests, sprite memory port) and the VGA emulator.

---
 rtl/chip8_fb_pkg.sv | 23 ++
 rtl/chip8_sprite_row_xor.sv | 28 ++
 rtl/chip8_fb_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/chip8_fb_pkg.sv
// Shared constants, FSM state type and pixel addressing helper for the Chip-8 framebuffer.
package chip8_fb_pkg;

    localparam int FB_W  = 64;
    localparam int FB_H  = 32;
    localparam int SPR_W = 8;
    localparam int X_W   = $clog2(FB_W);
    localparam int Y_W   = $clog2(FB_H);
    localparam int N_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        XOR,
        DONE
    } fb_state_t;

    function automatic int fb_index(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return int'(y) * FB_W + int'(x);
    endfunction

endpackage

// File: rtl/chip8_sprite_row_xor.sv
// Combinational merge of one sprite row into one framebuffer row, with wrap-around on x.
module chip8_sprite_row_xor
    import chip8_fb_pkg::*;
(
    input  logic [FB_W-1:0]  row,
    input  logic [SPR_W-1:0] spr,
    input  logic [X_W-1:0]   x,
    output logic [FB_W-1:0]  new_row,
    output logic             hit
);

    logic [FB_W-1:0] mask;
    logic [X_W-1:0]  col;

    // The column adder is X_W bits wide, so sprites running off the right edge wrap to column 0.
    always_comb begin
        mask = '0;
        col  = '0;
        for (int i = 0; i < SPR_W; i++) begin
            col       = x + X_W'(i);
            mask[col] = spr[SPR_W-1-i];
        end
    end

    assign new_row = row ^ mask;
    assign hit     = |(row & mask);

endmodule

// File: rtl/chip8_fb_controller.sv
// Chip-8 framebuffer owner: sequences clear and sprite XOR-draw requests and keeps a tear-free display copy.
module chip8_fb_controller
    import chip8_fb_pkg::*;
#(
    parameter bit COPY_ON_VBLANK = 1'b1
)
(
    input  logic                 clk50,
    input  logic                 reset,
    input  logic                 cls_req,
    input  logic                 draw_req,
    input  logic [X_W-1:0]       draw_x,
    input  logic [Y_W-1:0]       draw_y,
    input  logic [N_W-1:0]       draw_n,
    output logic [N_W-1:0]       spr_addr,
    input  logic [SPR_W-1:0]     spr_data,
    input  logic                 vblank_start,
    output logic                 busy,
    output logic                 done,
    output logic                 collision,
    output logic [FB_W*FB_H-1:0] framebuffer
);

    localparam logic [X_W-1:0] COL0 = '0;

    fb_state_t               state;
    logic [FB_W*FB_H-1:0]    work;
    logic [FB_W*FB_H-1:0]    display;
    logic [X_W-1:0]          x_lat;
    logic [Y_W-1:0]          y_lat;
    logic [N_W-1:0]          n_lat;
    logic [N_W-1:0]          r;
    logic [Y_W-1:0]          clr_row;
    logic                    vblank_pending;

    logic [Y_W-1:0]          row_sel;
    logic [FB_W-1:0]         cur_row;
    logic [FB_W-1:0]         new_row;
    logic                    hit;

    assign row_sel = y_lat + Y_W'(r);
    assign cur_row = work[fb_index(COL0, row_sel) +: FB_W];

    chip8_sprite_row_xor u_row_xor (
        .row     (cur_row),
        .spr     (spr_data),
        .x       (x_lat),
        .new_row (new_row),
        .hit     (hit)
    );

    // spr_addr is loaded on entry to FETCH, so the sprite RAM's data is ready in the following XOR cycle.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            work           <= '0;
            display        <= '0;
            x_lat          <= '0;
            y_lat          <= '0;
            n_lat          <= '0;
            r              <= '0;
            clr_row        <= '0;
            vblank_pending <= 1'b0;
            spr_addr       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            collision      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (COPY_ON_VBLANK) begin
                if (state == IDLE && (vblank_pending || vblank_start)) begin
                    display        <= work;
                    vblank_pending <= 1'b0;
                end else if (vblank_start) begin
                    vblank_pending <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (cls_req) begin
                        state     <= CLEAR;
                        clr_row   <= '0;
                        collision <= 1'b0;
                        busy      <= 1'b1;
                    end else if (draw_req) begin
                        x_lat     <= draw_x;
                        y_lat     <= draw_y;
                        n_lat     <= draw_n;
                        r         <= '0;
                        spr_addr  <= '0;
                        collision <= 1'b0;
                        busy      <= 1'b1;
                        if (draw_n == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                CLEAR: begin
                    work[fb_index(COL0, clr_row) +: FB_W] <= '0;
                    collision <= 1'b0;
                    if (clr_row == Y_W'(FB_H - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        clr_row <= clr_row + 1'b1;
                    end
                end
                FETCH: begin
                    state <= XOR;
                end
                XOR: begin
                    work[fb_index(COL0, row_sel) +: FB_W] <= new_row;
                    collision <= collision | hit;
                    if (r + 1'b1 == n_lat) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        r        <= r + 1'b1;
                        spr_addr <= r + 1'b1;
                        state    <= FETCH;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign framebuffer = COPY_ON_VBLANK ? display : work;

endmodule
